// File: rtl/lc3b_types.sv
// Shared types for the L2 cache controller.
//   lc3b_c2_way      : 2-bit way index of the 4-way L2
//   l2_ctrl_state_t  : sequencing FSM states
//   way_onehot()     : way index -> one-hot per-way enable vector
package lc3b_types;

    typedef logic [1:0] lc3b_c2_way;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL      = 2'd2
    } l2_ctrl_state_t;

    function automatic logic [3:0] way_onehot(input lc3b_c2_way w);
        way_onehot = 4'b0001 << w;
    endfunction

endpackage

// File: rtl/l2_event_counter.sv
// Saturating event counter.
//   clk, rst_n : clock, asynchronous active-low clear
//   i_inc      : count one event this cycle
//   o_count    : current count; holds at all-ones instead of wrapping
module l2_event_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/l2_cache_control.sv
// Sequencing FSM for the 4-way L2 cache datapath (L1 mem_* <-> pmem_*).
// Hits are served in one cycle; a miss writes back a dirty LRU victim, then
// fills it, then returns to idle where the request re-checks and hits.
//   mem_read/mem_write/mem_resp      : L1 request / completion pulse
//   pmem_read/pmem_write/pmem_resp   : physical memory request / done pulse
//   hit0..3, dirty0..3, lru          : per-set status from the datapath
//   lru_w, dataK_w/tagK_w/validK_w/dirtyK_w : array write enables
//   data_in_mux_sel, pmem_address_mux_sel, load_pmem_wdata : datapath muxes
//   hit_count, miss_count            : saturating event counters
//   o_state_dbg                      : current FSM state
// Handshake: mem_read/mem_write stay high until the mem_resp cycle;
// pmem_read/pmem_write stay high until the pmem_resp cycle.
module l2_cache_control
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit0, hit1, hit2, hit3,
    input  logic                 dirty0, dirty1, dirty2, dirty3,
    input  lc3b_c2_way           lru,
    output logic                 lru_w,
    output logic                 dirty0_w, dirty1_w, dirty2_w, dirty3_w,
    output logic                 valid0_w, valid1_w, valid2_w, valid3_w,
    output logic                 tag0_w, tag1_w, tag2_w, tag3_w,
    output logic                 data0_w, data1_w, data2_w, data3_w,
    output logic                 data_in_mux_sel,
    output logic [2:0]           pmem_address_mux_sel,
    output logic                 load_pmem_wdata,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output l2_ctrl_state_t       o_state_dbg
);

    l2_ctrl_state_t r_state, w_next;
    lc3b_c2_way     r_victim;
    logic           r_miss_pend;

    logic       w_req, w_any_hit, w_miss_det;
    lc3b_c2_way w_hit_way, w_way;
    logic [3:0] w_dirty_vec, w_way_oh;
    logic       w_data_we, w_dirty_we, w_tag_we, w_valid_we;

    assign w_req       = mem_read | mem_write;
    assign w_any_hit   = hit0 | hit1 | hit2 | hit3;
    assign w_hit_way   = hit0 ? 2'd0 : hit1 ? 2'd1 : hit2 ? 2'd2 : 2'd3;
    assign w_dirty_vec = {dirty3, dirty2, dirty1, dirty0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_victim    <= '0;
            r_miss_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_miss_det) begin
                // Victim is latched once; later lru changes do not redirect the miss.
                r_victim    <= lru;
                r_miss_pend <= 1'b1;
            end else if (mem_resp) begin
                r_miss_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next               = r_state;
        w_miss_det           = 1'b0;
        w_way                = r_victim;
        w_data_we            = 1'b0;
        w_dirty_we           = 1'b0;
        w_tag_we             = 1'b0;
        w_valid_we           = 1'b0;
        mem_resp             = 1'b0;
        lru_w                = 1'b0;
        pmem_read            = 1'b0;
        pmem_write           = 1'b0;
        data_in_mux_sel      = 1'b0;
        pmem_address_mux_sel = 3'd0;
        load_pmem_wdata      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req && w_any_hit) begin
                    w_way    = w_hit_way;
                    mem_resp = 1'b1;
                    lru_w    = 1'b1;
                    if (mem_write) begin
                        data_in_mux_sel = 1'b1;
                        w_data_we       = 1'b1;
                        w_dirty_we      = 1'b1;
                    end
                end else if (w_req) begin
                    w_miss_det = 1'b1;
                    w_next     = w_dirty_vec[lru] ? S_WRITEBACK : S_FILL;
                end
            end
            S_WRITEBACK: begin
                pmem_write           = 1'b1;
                pmem_address_mux_sel = {1'b0, r_victim} + 3'd1;
                load_pmem_wdata      = 1'b1;
                // A request dropped mid-miss still finishes this transfer, then idles.
                if (pmem_resp) w_next = w_req ? S_FILL : S_IDLE;
            end
            S_FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    w_data_we  = 1'b1;
                    w_tag_we   = 1'b1;
                    w_valid_we = 1'b1;
                    w_dirty_we = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Every output is forced low while reset is asserted.
        if (!rst_n) begin
            w_data_we            = 1'b0;
            w_dirty_we           = 1'b0;
            w_tag_we             = 1'b0;
            w_valid_we           = 1'b0;
            mem_resp             = 1'b0;
            lru_w                = 1'b0;
            pmem_read            = 1'b0;
            pmem_write           = 1'b0;
            data_in_mux_sel      = 1'b0;
            pmem_address_mux_sel = 3'd0;
            load_pmem_wdata      = 1'b0;
        end
    end

    assign w_way_oh = way_onehot(w_way);

    assign {data3_w,  data2_w,  data1_w,  data0_w}  = w_way_oh & {4{w_data_we}};
    assign {dirty3_w, dirty2_w, dirty1_w, dirty0_w} = w_way_oh & {4{w_dirty_we}};
    assign {tag3_w,   tag2_w,   tag1_w,   tag0_w}   = w_way_oh & {4{w_tag_we}};
    assign {valid3_w, valid2_w, valid1_w, valid0_w} = w_way_oh & {4{w_valid_we}};

    assign o_state_dbg = r_state;

    l2_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (mem_resp & ~r_miss_pend),
        .o_count (hit_count)
    );

    l2_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_miss_det),
        .o_count (miss_count)
    );

endmodule

// File: tb/tb_l2_cache_control.sv
module tb_l2_cache_control;
  import lc3b_types::*;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
  logic hit0, hit1, hit2, hit3;
  logic dirty0, dirty1, dirty2, dirty3;
  logic [1:0] lru = 2'd0;
  logic mem_resp, pmem_read, pmem_write, lru_w;
  logic dirty0_w, dirty1_w, dirty2_w, dirty3_w;
  logic valid0_w, valid1_w, valid2_w, valid3_w;
  logic tag0_w, tag1_w, tag2_w, tag3_w;
  logic data0_w, data1_w, data2_w, data3_w;
  logic data_in_mux_sel, load_pmem_wdata;
  logic [2:0] pmem_address_mux_sel;
  logic [CW-1:0] hit_count, miss_count;
  l2_ctrl_state_t state_dbg;

  // environment: which ways hold the requested line, dirty bits of the set
  logic [3:0] line_present = 4'b0;
  logic [3:0] dirty_bits = 4'b0;
  assign {hit3, hit2, hit1, hit0} = (mem_read | mem_write) ? line_present : 4'b0;
  assign {dirty3, dirty2, dirty1, dirty0} = dirty_bits;

  wire [3:0] v_data  = {data3_w, data2_w, data1_w, data0_w};
  wire [3:0] v_dirty = {dirty3_w, dirty2_w, dirty1_w, dirty0_w};
  wire [3:0] v_tag   = {tag3_w, tag2_w, tag1_w, tag0_w};
  wire [3:0] v_valid = {valid3_w, valid2_w, valid1_w, valid0_w};
  wire [17:0] resp_snap = {data_in_mux_sel, lru_w, v_data, v_dirty, v_tag, v_valid};

  l2_cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit0(hit0), .hit1(hit1), .hit2(hit2), .hit3(hit3),
    .dirty0(dirty0), .dirty1(dirty1), .dirty2(dirty2), .dirty3(dirty3),
    .lru(lru), .lru_w(lru_w),
    .dirty0_w(dirty0_w), .dirty1_w(dirty1_w), .dirty2_w(dirty2_w), .dirty3_w(dirty3_w),
    .valid0_w(valid0_w), .valid1_w(valid1_w), .valid2_w(valid2_w), .valid3_w(valid3_w),
    .tag0_w(tag0_w), .tag1_w(tag1_w), .tag2_w(tag2_w), .tag3_w(tag3_w),
    .data0_w(data0_w), .data1_w(data1_w), .data2_w(data2_w), .data3_w(data3_w),
    .data_in_mux_sel(data_in_mux_sel),
    .pmem_address_mux_sel(pmem_address_mux_sel),
    .load_pmem_wdata(load_pmem_wdata),
    .hit_count(hit_count), .miss_count(miss_count),
    .o_state_dbg(state_dbg)
  );

  // scoreboard
  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  bit mp = 1'b0;
  int pcnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [3:0] prio_oh(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return 4'b0001 << k;
    return 4'b0;
  endfunction

  // pmem responder: pulses pmem_resp on the lat-th cycle of each transfer
  task automatic tick(input int lat);
    @(negedge clk);
    if (pmem_read || pmem_write) begin
      pcnt++;
      if (pcnt >= lat) begin pmem_resp = 1'b1; pcnt = 0; end
      else pmem_resp = 1'b0;
    end else begin
      pcnt = 0;
      pmem_resp = 1'b0;
    end
  endtask

  task automatic run_req(input bit wr, input int lat, input logic [1:0] lru_mid);
    logic [3:0] oh;
    logic [1:0] vq;
    bit is_miss, wb_exp, done;
    int wb_cyc, fill_cyc, cyc, exp_cyc;
    is_miss = (line_present == 4'b0);
    vq = lru;
    wb_exp = is_miss && dirty_bits[lru];
    oh = is_miss ? (4'b0001 << lru) : prio_oh(line_present);
    exp_q.push_back({wr, 1'b1, wr ? oh : 4'b0, wr ? oh : 4'b0, 4'b0, 4'b0});
    if (is_miss) begin
      exp_miss = sat_inc(exp_miss);
      mp = 1'b1;
    end else if (!mp) begin
      exp_hit = sat_inc(exp_hit);
    end
    done = 1'b0; wb_cyc = 0; fill_cyc = 0; cyc = 0;
    while (!done && cyc < 200) begin
      tick(lat);
      mem_read = !wr;
      mem_write = wr;
      #1;
      if (pmem_write) begin
        wb_cyc++;
        check_eq("wb_addr_sel", {29'd0, pmem_address_mux_sel}, {29'd0, {1'b0, vq} + 3'd1});
        check_eq("wb_load", {31'd0, load_pmem_wdata}, 32'd1);
        lru = lru_mid;
      end
      if (pmem_read) begin
        fill_cyc++;
        check_eq("fill_addr_sel", {29'd0, pmem_address_mux_sel}, 32'd0);
      end
      if (v_tag != 4'b0) begin
        check_eq("fill_enables", {16'd0, v_data, v_tag, v_valid, v_dirty}, {16'd0, {4{oh}}});
        check_eq("fill_mux", {31'd0, data_in_mux_sel}, 32'd0);
        line_present = oh;
      end
      if (mem_resp) begin
        check_eq("resp_outputs", {14'd0, resp_snap}, {14'd0, exp_q.pop_front()});
        done = 1'b1;
      end
      cyc++;
    end
    check_eq("resp_seen", {31'd0, done}, 32'd1);
    check_eq("wb_cycles", wb_cyc, wb_exp ? lat : 0);
    check_eq("fill_cycles", fill_cyc, is_miss ? lat : 0);
    exp_cyc = is_miss ? ((wb_exp ? lat : 0) + lat + 2) : 1;
    check_eq("latency", cyc, exp_cyc);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mp = 1'b0;
    check_eq("hit_count", {28'd0, hit_count}, exp_hit);
    check_eq("miss_count", {28'd0, miss_count}, exp_miss);
  endtask

  initial begin
    int guard;
    // reset state
    line_present = 4'b0001;
    mem_read = 1'b1;
    #12;
    check_eq("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
    check_eq("rst_lru_w", {31'd0, lru_w}, 32'd0);
    check_eq("rst_counts", {24'd0, hit_count, miss_count}, 32'd0);
    check_eq("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // read hit in way 2
    line_present = 4'b0100;
    run_req(1'b0, 4, 2'd0);
    // write hit, ways 1 and 3 both hit: way 1 wins
    line_present = 4'b1010;
    run_req(1'b1, 4, 2'd0);
    // clean read miss into way 3
    line_present = 4'b0000; lru = 2'd3; dirty_bits = 4'b0000;
    run_req(1'b0, 4, 2'd3);
    // dirty write miss on way 0, lru moves to 2 during writeback
    line_present = 4'b0000; lru = 2'd0; dirty_bits = 4'b0001;
    run_req(1'b1, 3, 2'd2);
    // dirty miss with random PMEM latency
    line_present = 4'b0000; lru = 2'($urandom_range(0, 3)); dirty_bits = 4'b1111;
    run_req(1'b0, int'($urandom_range(1, 6)), 2'd1);

    // request dropped during writeback: transfer completes, no fill, no resp
    line_present = 4'b0000; lru = 2'd1; dirty_bits = 4'b0010;
    exp_miss = sat_inc(exp_miss);
    tick(3); mem_read = 1'b1; #1;
    check_eq("drop_detect_resp", {31'd0, mem_resp}, 32'd0);
    tick(3); mem_read = 1'b0; #1;
    check_eq("drop_in_wb", {31'd0, pmem_write}, 32'd1);
    guard = 0;
    while (pmem_write && guard < 20) begin
      tick(3); #1;
      check_eq("drop_no_read", {31'd0, pmem_read}, 32'd0);
      check_eq("drop_no_resp", {31'd0, mem_resp}, 32'd0);
      guard++;
    end
    check_eq("drop_wb_done", {31'd0, pmem_write}, 32'd0);
    check_eq("drop_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    check_eq("drop_miss_count", {28'd0, miss_count}, exp_miss);

    // reset during fill
    line_present = 4'b0000; lru = 2'd2; dirty_bits = 4'b0000;
    guard = 0;
    tick(50); mem_read = 1'b1; #1;
    while (!pmem_read && guard < 10) begin tick(50); #1; guard++; end
    check_eq("fill_reached", {31'd0, pmem_read}, 32'd1);
    rst_n = 1'b0;
    line_present = 4'b0001;
    #1;
    check_eq("rst_fill_pmem_read", {31'd0, pmem_read}, 32'd0);
    check_eq("rst_fill_mem_resp", {31'd0, mem_resp}, 32'd0);
    check_eq("rst_fill_counts", {24'd0, hit_count, miss_count}, 32'd0);
    check_eq("rst_fill_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    mem_read = 1'b0; pmem_resp = 1'b0; pcnt = 0;
    exp_hit = 0; exp_miss = 0; mp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // stray pmem_resp in idle is ignored
    @(negedge clk); pmem_resp = 1'b1; #1;
    check_eq("idle_resp_no_pmem", {30'd0, pmem_read, pmem_write}, 32'd0);
    @(negedge clk); pmem_resp = 1'b0; #1;
    check_eq("idle_resp_state", {30'd0, state_dbg}, {30'd0, S_IDLE});

    // 20 read hits: hit_count saturates at all-ones
    line_present = 4'b1000;
    for (int i = 0; i < 20; i++) run_req(1'b0, 4, 2'd0);
    check_eq("sat_hit_count", {28'd0, hit_count}, CMAX);
    check_eq("sat_miss_count", {28'd0, miss_count}, 32'd0);
    check_eq("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
